// File: rtl/vec_data_mem_arbiter.sv
// Arbitrates the single OBI data port between the core LSU and the vector accelerator,
// tracks the owner of each outstanding transaction and routes in-order responses back.
module vec_data_mem_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // core LSU master
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [3:0]  core_be_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    output logic        core_gnt_o,
    output logic        core_rvalid_o,
    output logic [31:0] core_rdata_o,
    // accelerator master
    input  logic        acc_req_i,
    input  logic        acc_we_i,
    input  logic [3:0]  acc_be_i,
    input  logic [31:0] acc_addr_i,
    input  logic [31:0] acc_wdata_i,
    output logic        acc_gnt_o,
    output logic        acc_rvalid_o,
    output logic [31:0] acc_rdata_o,
    input  logic        acc_lock_i,
    // memory slave port
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    output logic        protocol_err_o
);

    // A request transfers on req & gnt; responses return in order, one per transfer.
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {
        ID_CORE = 1'b0,
        ID_ACC  = 1'b1
    } owner_e;

    owner_e          owner_q [MAX_OUTSTANDING];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    owner_e          rr_q, pending_id_q, win_id, head;
    logic            pending_q, win_req, hs, pop, sel_acc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    // A stalled request keeps its master until granted, regardless of lock or RR.
    always_comb begin
        win_id  = ID_CORE;
        win_req = 1'b0;
        if (pending_q) begin
            win_id  = pending_id_q;
            win_req = (pending_id_q == ID_ACC) ? acc_req_i : core_req_i;
        end else if (acc_lock_i) begin
            win_id  = ID_ACC;
            win_req = acc_req_i;
        end else if (core_req_i && acc_req_i) begin
            win_id  = rr_q;
            win_req = 1'b1;
        end else if (acc_req_i) begin
            win_id  = ID_ACC;
            win_req = 1'b1;
        end else if (core_req_i) begin
            win_id  = ID_CORE;
            win_req = 1'b1;
        end
    end

    assign sel_acc      = (win_id == ID_ACC);
    assign data_req_o   = win_req && (count_q < CW'(MAX_OUTSTANDING));
    assign hs           = data_req_o && data_gnt_i;
    assign core_gnt_o   = hs && !sel_acc;
    assign acc_gnt_o    = hs && sel_acc;

    assign data_we_o    = data_req_o && (sel_acc ? acc_we_i : core_we_i);
    assign data_be_o    = data_req_o ? (sel_acc ? acc_be_i    : core_be_i)    : 4'h0;
    assign data_addr_o  = data_req_o ? (sel_acc ? acc_addr_i  : core_addr_i)  : 32'h0;
    assign data_wdata_o = data_req_o ? (sel_acc ? acc_wdata_i : core_wdata_i) : 32'h0;

    assign head          = owner_q[rd_ptr_q];
    assign pop           = data_rvalid_i && (count_q != '0);
    assign core_rvalid_o = pop && (head == ID_CORE);
    assign acc_rvalid_o  = pop && (head == ID_ACC);
    assign core_rdata_o  = data_rdata_i;
    assign acc_rdata_o   = data_rdata_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) owner_q[i] <= ID_CORE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            rr_q           <= ID_CORE;
            pending_q      <= 1'b0;
            pending_id_q   <= ID_CORE;
            protocol_err_o <= 1'b0;
        end else begin
            pending_q <= data_req_o && !data_gnt_i;
            if (data_req_o && !data_gnt_i) pending_id_q <= win_id;
            if (hs) begin
                owner_q[wr_ptr_q] <= win_id;
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
                rr_q              <= sel_acc ? ID_CORE : ID_ACC;
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (hs && !pop)      count_q <= count_q + CW'(1);
            else if (!hs && pop) count_q <= count_q - CW'(1);
            if (data_rvalid_i && count_q == '0) protocol_err_o <= 1'b1;
        end
    end

endmodule
